// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote
// Brief    : Majority vote over the K sorted neighbour labels read back from
//            the KNN sorter; ties go to the class holding the nearest slot.
// Revision : 1.0 - initial release
// ============================================================================
module knn_vote #(
    parameter int K        = 10,
    parameter int NCLASSES = 10,
    parameter int LABEL_W  = 8,
    parameter int SEL_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic [SEL_W-1:0]   sel,
    input  logic [LABEL_W-1:0] label_in,
    output logic               done,
    output logic [LABEL_W-1:0] class_out,
    output logic [4:0]         votes_out,
    output logic               no_vote,
    output logic [4:0]         bad_labels
);

    localparam int CNT_W  = $clog2(K + 1);
    localparam int CIDX_W = (NCLASSES > 1) ? $clog2(NCLASSES) : 1;

    localparam logic [CNT_W-1:0]  c_unseen    = CNT_W'(K);
    localparam logic [SEL_W-1:0]  c_last_slot = SEL_W'(K - 1);
    localparam logic [CIDX_W-1:0] c_last_cls  = CIDX_W'(NCLASSES - 1);
    localparam logic [31:0]       c_ncls      = 32'(NCLASSES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_READ   = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count [NCLASSES];
    logic [CNT_W-1:0]  r_first [NCLASSES];
    logic [CNT_W-1:0]  r_bad;
    logic [CIDX_W-1:0] r_cls;
    logic [CIDX_W-1:0] r_bc;
    logic [CNT_W-1:0]  r_bn;
    logic [CNT_W-1:0]  r_bf;

    logic              w_valid;
    logic [CIDX_W-1:0] w_lbl;
    logic [CNT_W-1:0]  w_cnt_c;
    logic [CNT_W-1:0]  w_first_c;
    logic              w_take;
    logic [CIDX_W-1:0] w_bc;
    logic [CNT_W-1:0]  w_bn;
    logic [CNT_W-1:0]  w_bf;

    always_comb begin
        w_valid   = (32'(label_in) < c_ncls);
        w_lbl     = label_in[CIDX_W-1:0];
        w_cnt_c   = r_count[r_cls];
        w_first_c = r_first[r_cls];
        // Equal non-zero counts resolve towards the class seen at the nearer slot.
        w_take    = (w_cnt_c > r_bn) ||
                    ((w_cnt_c == r_bn) && (w_cnt_c != '0) && (w_first_c < r_bf));
        w_bc      = w_take ? r_cls     : r_bc;
        w_bn      = w_take ? w_cnt_c   : r_bn;
        w_bf      = w_take ? w_first_c : r_bf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sel        <= '0;
            class_out  <= '0;
            votes_out  <= '0;
            no_vote    <= 1'b0;
            bad_labels <= '0;
            r_bad      <= '0;
            r_cls      <= '0;
            r_bc       <= '0;
            r_bn       <= '0;
            r_bf       <= '0;
            for (int c = 0; c < NCLASSES; c++) begin
                r_count[c] <= '0;
                r_first[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    sel <= '0;
                    if (start) begin
                        r_state <= S_CLEAR;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    for (int c = 0; c < NCLASSES; c++) begin
                        r_count[c] <= '0;
                        r_first[c] <= c_unseen;
                    end
                    r_bad   <= '0;
                    sel     <= '0;
                    r_state <= S_READ;
                end
                S_READ: begin
                    if (w_valid) begin
                        r_count[w_lbl] <= r_count[w_lbl] + CNT_W'(1);
                        if (r_first[w_lbl] == c_unseen)
                            r_first[w_lbl] <= CNT_W'(sel);
                    end else begin
                        r_bad <= r_bad + CNT_W'(1);
                    end
                    if (sel == c_last_slot) begin
                        sel     <= '0;
                        r_cls   <= '0;
                        r_bc    <= '0;
                        r_bn    <= '0;
                        r_bf    <= c_unseen;
                        r_state <= S_ARGMAX;
                    end else begin
                        sel <= sel + SEL_W'(1);
                    end
                end
                S_ARGMAX: begin
                    r_bc <= w_bc;
                    r_bn <= w_bn;
                    r_bf <= w_bf;
                    if (r_cls == c_last_cls) begin
                        r_state    <= S_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        class_out  <= (w_bn == '0) ? '0 : LABEL_W'(w_bc);
                        votes_out  <= 5'(w_bn);
                        no_vote    <= (w_bn == '0);
                        bad_labels <= 5'(r_bad);
                    end else begin
                        r_cls <= r_cls + CIDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_vote
// Brief    : Self-checking bench for knn_vote against a slot-scan vote model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_knn_vote;

    localparam int K  = 10;
    localparam int NC = 10;
    localparam int LATENCY = 2 + K + NC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, no_vote;
    logic [3:0] sel;
    logic [7:0] label_in, class_out;
    logic [4:0] votes_out, bad_labels;
    logic [7:0] lab [16];

    logic       start1 = 1'b0;
    logic       busy1, done1, no_vote1;
    logic [0:0] sel1;
    logic [7:0] label1, class1;
    logic [4:0] votes1, bad1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign label_in = lab[sel];

    knn_vote #(.K(K), .NCLASSES(NC), .LABEL_W(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .sel(sel),
        .label_in(label_in), .done(done), .class_out(class_out),
        .votes_out(votes_out), .no_vote(no_vote), .bad_labels(bad_labels)
    );

    knn_vote #(.K(1), .NCLASSES(2), .LABEL_W(8), .SEL_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .sel(sel1),
        .label_in(label1), .done(done1), .class_out(class1),
        .votes_out(votes1), .no_vote(no_vote1), .bad_labels(bad1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Winner = label of the nearest slot whose class reaches the maximum count.
    task automatic model(output int cls, output int votes, output int nv, output int bad);
        int cnt [256];
        int mx;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        bad = 0;
        mx  = 0;
        for (int s = 0; s < K; s++) begin
            if (int'(lab[s]) < NC) cnt[lab[s]]++;
            else bad++;
        end
        for (int i = 0; i < NC; i++) if (cnt[i] > mx) mx = cnt[i];
        cls = 0; votes = mx; nv = (mx == 0);
        if (mx > 0) begin
            for (int s = K - 1; s >= 0; s--)
                if (int'(lab[s]) < NC && cnt[lab[s]] == mx) cls = int'(lab[s]);
        end
    endtask

    task automatic set_labels(input int v0, input int v1, input int v2, input int v3, input int v4,
                              input int v5, input int v6, input int v7, input int v8, input int v9);
        lab[0] = 8'(v0); lab[1] = 8'(v1); lab[2] = 8'(v2); lab[3] = 8'(v3); lab[4] = 8'(v4);
        lab[5] = 8'(v5); lab[6] = 8'(v6); lab[7] = 8'(v7); lab[8] = 8'(v8); lab[9] = 8'(v9);
    endtask

    // Called just after a clock edge with the DUT idle; returns after the cycle following done.
    task automatic run_vote(input string tag, input int hold, input int poke);
        int ecls, evotes, env, ebad;
        int c, busy_n, sel_err;
        bit got_done;
        model(ecls, evotes, env, ebad);
        start = 1'b1;
        c = 0; busy_n = 0; sel_err = 0; got_done = 0;
        while (!got_done && c < 60) begin
            @(posedge clk); #1;
            c++;
            start = (c < hold) || (c == poke);
            if (c >= 2 && c <= K + 1) sel_err += (int'(sel) != c - 2);
            else sel_err += (sel != 4'd0);
            if (done) got_done = 1;
            else if (busy) busy_n++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        if (got_done) begin
            chk({tag, "_latency"}, 32'(c), 32'(LATENCY));
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(LATENCY - 1));
            chk({tag, "_busy_at_done"}, 32'(busy), 0);
            chk({tag, "_sel_sweep_errs"}, 32'(sel_err), 0);
            chk({tag, "_class"}, 32'(class_out), 32'(ecls));
            chk({tag, "_votes"}, 32'(votes_out), 32'(evotes));
            chk({tag, "_no_vote"}, 32'(no_vote), 32'(env));
            chk({tag, "_bad"}, 32'(bad_labels), 32'(ebad));
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, 32'(done), 0);
            chk({tag, "_busy_after"}, 32'(busy), 0);
            chk({tag, "_class_held"}, 32'(class_out), 32'(ecls));
        end
    endtask

    initial begin
        int c, seen;
        for (int i = 0; i < 16; i++) lab[i] = 8'd0;
        label1 = 8'd1;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_class", 32'(class_out), 0);
        chk("rst_votes", 32'(votes_out), 0);
        chk("rst_no_vote", 32'(no_vote), 0);
        chk("rst_bad", 32'(bad_labels), 0);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #1;

        set_labels(3, 3, 3, 1, 1, 2, 2, 2, 2, 5);
        run_vote("basic", 1, -1);
        chk("basic_class_const", 32'(class_out), 2);
        chk("basic_votes_const", 32'(votes_out), 4);

        set_labels(7, 1, 1, 7, 4, 4, 4, 1, 7, 9);
        run_vote("tie", 1, -1);
        chk("tie_class_const", 32'(class_out), 7);

        set_labels(12, 200, 5, 12, 12, 12, 12, 12, 12, 12);
        run_vote("invalid", 1, -1);
        chk("invalid_bad_const", 32'(bad_labels), 9);

        set_labels(15, 15, 15, 15, 15, 15, 15, 15, 15, 15);
        run_vote("all_bad", 1, -1);
        chk("all_bad_no_vote_const", 32'(no_vote), 1);

        set_labels(3, 3, 3, 1, 1, 2, 2, 2, 2, 5);
        run_vote("hold3", 3, -1);
        set_labels(0, 9, 9, 0, 8, 8, 8, 6, 6, 0);
        run_vote("poke_mid_read", 1, 5);
        set_labels(4, 4, 2, 2, 1, 1, 1, 11, 2, 4);
        run_vote("back2back", 1, -1);

        for (int r = 0; r < 20; r++) begin
            int narrow;
            narrow = $urandom_range(0, 1);
            for (int s = 0; s < K; s++) begin
                if ($urandom_range(0, 99) < 12) lab[s] = 8'($urandom_range(10, 255));
                else lab[s] = 8'($urandom_range(0, narrow ? 3 : 9));
            end
            run_vote($sformatf("rand%0d", r), 1, -1);
        end

        // Asynchronous reset in the middle of ARGMAX
        set_labels(3, 3, 3, 1, 1, 2, 2, 2, 2, 5);
        run_vote("pre_reset", 1, -1);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #3; rst = 1'b0; #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_class", 32'(class_out), 0);
        chk("arst_sel", 32'(sel), 0);
        seen = 0;
        for (c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            seen += int'(done) + int'(busy);
        end
        chk("arst_quiet", 32'(seen), 0);
        #2; rst = 1'b1;
        @(posedge clk); #1;
        run_vote("post_reset", 1, -1);
        chk("post_reset_class_const", 32'(class_out), 2);

        // Smallest configuration: K=1, NCLASSES=2
        label1 = 8'd1;
        start1 = 1'b1;
        seen = 0;
        for (c = 1; c <= 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (done1) seen = c;
        end
        chk("k1_latency", 32'(seen), 5);
        chk("k1_class", 32'(class1), 1);
        chk("k1_votes", 32'(votes1), 1);
        chk("k1_no_vote", 32'(no_vote1), 0);
        @(posedge clk); #1;
        label1 = 8'd3;
        start1 = 1'b1;
        seen = 0;
        for (c = 1; c <= 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (done1) seen = c;
        end
        chk("k1_bad_latency", 32'(seen), 5);
        chk("k1_bad_no_vote", 32'(no_vote1), 1);
        chk("k1_bad_count", 32'(bad1), 1);
        chk("k1_bad_class", 32'(class1), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
